dk_audio_post: RTL and testbench
================================

Name: dk_audio_post

Overview:
Post-processing stage directly downstream of the Donkey Kong sound board mixer. It consumes the 48 kHz unsigned mix sample and its strobe, removes the DC offset, applies an optional one-pole low-pass, gain, volume attenuation and mute, and saturates. It emits a signed 16-bit sample with a one-cycle valid strobe to the top-level audio output.

Parameters:
OFFSET, 16384, unsigned midpoint subtracted from the input to centre it
DCB_SHIFT, 8, DC-blocker pole: leak term y[n-1]>>>DCB_SHIFT
LPF_SHIFT, 2, low-pass coefficient: z += (y-z)>>>LPF_SHIFT
GAIN_SHIFT, 1, post-filter gain as left shift, applied before volume

Ports:
W_CLK_24M  in  1  system clock, 24 MHz
W_RESETn  in  1  asynchronous active-low reset
I_SAMPLE  in  16  unsigned mixed sample; bit 15 ignored, bits 14:0 used
I_SAMPLE_VALID  in  1  one-cycle strobe, nominally every 500 clocks
I_VOL  in  4  attenuation as arithmetic right shift; 0 = full, 15 = minimum
I_MUTE  in  1  forces output to 0 while high; sampled at the OUT state
O_AUDIO  out  16  signed output sample, held between strobes
O_VALID  out  1  one-cycle strobe when O_AUDIO updates
O_CLIP  out  1  sticky; set on any saturation event
O_OVERRUN  out  1  sticky; set when a strobe arrives while the FSM is busy

Behaviour:
- Reset (async, W_RESETn low): O_AUDIO=0, O_VALID=0, O_CLIP=0, O_OVERRUN=0.
- Reset also clears all state (x_prev, y, z) to 0 and sets FSM=IDLE.
- A reset asserted mid-operation abandons the sample in flight; no O_VALID is produced for it.
- FSM states: IDLE, DCB, LPF, GAIN, OUT. One clock per state.
- IDLE: on I_SAMPLE_VALID, latch x = {3'b0, I_SAMPLE[14:0]} - OFFSET as signed 18-bit, then go to DCB.
- DCB:
  - y_new = x - x_prev + y - (y>>>DCB_SHIFT), computed at 18 bits.
  - Saturate y_new to ±2^17 (2^17-1 positive). Saturation sets O_CLIP.
  - Update x_prev<=x and y<=y_new, then go to LPF.
- LPF: z <= z + ((y - z)>>>LPF_SHIFT) at 18 bits with saturation, then go to GAIN.
- GAIN: g = sat16(z <<< GAIN_SHIFT), range -32768..32767. Clipping sets O_CLIP. Go to OUT.
- OUT:
  - O_AUDIO <= I_MUTE ? 0 : (g >>> I_VOL). Arithmetic shift; -1>>>n stays -1.
  - O_VALID=1 for exactly this cycle, then go to IDLE.
- Latency: O_VALID asserts 4 clocks after the clock in which I_SAMPLE_VALID is sampled in IDLE (3 clocks without the LPF).
- I_SAMPLE_VALID in any non-IDLE state: the sample is dropped, O_OVERRUN is set, and the in-flight sample completes normally.
- I_SAMPLE_VALID in the same cycle as OUT is also dropped, since the FSM is not yet in IDLE.
- All arithmetic is signed two's complement, and every shift is arithmetic.
- Sticky flags clear only on reset.
- I_VOL and I_MUTE are sampled only in OUT; changes at other times have no effect on the current sample.

Optional Feature:
DK_AUDIO_LPF_EN:
- Defined: the LPF state and z register exist as described, and latency is 4.
- Undefined: the LPF state is removed and DCB goes directly to GAIN. GAIN uses y in place of z, latency is 3, and no z register is synthesised.

Test Plan:
1. Reset, then 10 strobes with I_SAMPLE=16384 (midpoint) -> every O_AUDIO=0, O_VALID count=10, O_CLIP=0, O_OVERRUN=0.
2. Step test (LPF_EN defined, defaults):
   - Stimulus: I_SAMPLE goes 16384→24576 on one strobe, I_VOL=0.
   - First O_AUDIO=4096, with O_VALID exactly 4 clocks after the strobe.
   - Later samples move toward 0 as the DC blocker leaks.
   - Without the macro, the first O_AUDIO=16384 at 3 clocks.
3. Volume: same step with I_VOL=3 -> first O_AUDIO=512. Same step with I_MUTE=1 -> O_AUDIO=0, and O_VALID still pulses.
4. Saturation: GAIN_SHIFT=2, LPF undefined, step 16384→32767 -> y=16383, O_AUDIO=32767, O_CLIP=1 and stays set.
5. Overrun: second strobe 2 clocks after the first -> one O_VALID only, O_OVERRUN=1, first sample value unaffected.
6. Reset mid-operation: assert W_RESETn low 2 clocks after a strobe -> no O_VALID, all outputs 0. The next strobe at midpoint yields O_AUDIO=0.

Source files
------------

// File: rtl/dk_audio_post.sv
// dk_audio_post: DC blocker, optional one-pole low-pass, gain, volume and mute for the DK sound mix.
// Define DK_AUDIO_LPF_EN to build the low-pass stage (latency 4); without it latency is 3.
module dk_audio_post #(
    parameter int OFFSET     = 16384,
    parameter int DCB_SHIFT  = 8,
    parameter int LPF_SHIFT  = 2,
    parameter int GAIN_SHIFT = 1
) (
    input  logic        W_CLK_24M,
    input  logic        W_RESETn,
    input  logic [15:0] I_SAMPLE,
    input  logic        I_SAMPLE_VALID,
    input  logic [3:0]  I_VOL,
    input  logic        I_MUTE,
    output logic [15:0] O_AUDIO,
    output logic        O_VALID,
    output logic        O_CLIP,
    output logic        O_OVERRUN
);

    typedef enum logic [2:0] {IDLE, DCB, LPF, GAIN, OUT} state_t;

    state_t             state;
    logic signed [17:0] x;
    logic signed [17:0] x_prev;
    logic signed [17:0] y;
    logic signed [15:0] g;

    logic signed [17:0] x_in;
    logic signed [19:0] x_w;
    logic signed [19:0] xp_w;
    logic signed [19:0] y_w;
    logic signed [19:0] leak_w;
    logic signed [19:0] dcb_sum;
    logic signed [17:0] y_next;
    logic               dcb_clip;

    logic signed [17:0] filt;
    logic signed [31:0] gain_w;
    logic signed [15:0] gain_sat;
    logic               gain_clip;
    logic signed [15:0] vol_out;
    logic               unused_bit;

    assign unused_bit = I_SAMPLE[15];
    assign x_in       = $signed({3'b000, I_SAMPLE[14:0]}) - $signed(18'(OFFSET));
    assign vol_out    = g >>> I_VOL;

    // DC blocker computed with two guard bits, then clamped back to 18 bits
    always_comb begin
        x_w     = 20'(x);
        xp_w    = 20'(x_prev);
        y_w     = 20'(y);
        leak_w  = 20'(y >>> DCB_SHIFT);
        dcb_sum = x_w - xp_w + y_w - leak_w;
        y_next  = dcb_sum[17:0];
        dcb_clip = 1'b0;
        if (dcb_sum > 20'sd131071) begin
            y_next   = {1'b0, {17{1'b1}}};
            dcb_clip = 1'b1;
        end else if (dcb_sum < -20'sd131072) begin
            y_next   = {1'b1, 17'b0};
            dcb_clip = 1'b1;
        end
    end

`ifdef DK_AUDIO_LPF_EN
    logic signed [17:0] z;
    logic signed [19:0] z_w;
    logic signed [19:0] lpf_sum;
    logic signed [17:0] z_next;
    logic               lpf_clip;

    always_comb begin
        z_w      = 20'(z);
        lpf_sum  = z_w + ((y_w - z_w) >>> LPF_SHIFT);
        z_next   = lpf_sum[17:0];
        lpf_clip = 1'b0;
        if (lpf_sum > 20'sd131071) begin
            z_next   = {1'b0, {17{1'b1}}};
            lpf_clip = 1'b1;
        end else if (lpf_sum < -20'sd131072) begin
            z_next   = {1'b1, 17'b0};
            lpf_clip = 1'b1;
        end
    end

    assign filt = z;
`else
    assign filt = y;
`endif

    // Gain stage clamps into the 16-bit output range
    always_comb begin
        gain_w    = 32'(filt) <<< GAIN_SHIFT;
        gain_sat  = gain_w[15:0];
        gain_clip = 1'b0;
        if (gain_w > 32'sd32767) begin
            gain_sat  = {1'b0, {15{1'b1}}};
            gain_clip = 1'b1;
        end else if (gain_w < -32'sd32768) begin
            gain_sat  = {1'b1, 15'b0};
            gain_clip = 1'b1;
        end
    end

    always_ff @(posedge W_CLK_24M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            state     <= IDLE;
            x         <= '0;
            x_prev    <= '0;
            y         <= '0;
`ifdef DK_AUDIO_LPF_EN
            z         <= '0;
`endif
            g         <= '0;
            O_AUDIO   <= '0;
            O_VALID   <= 1'b0;
            O_CLIP    <= 1'b0;
            O_OVERRUN <= 1'b0;
        end else begin
            O_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_SAMPLE_VALID) begin
                        x     <= x_in;
                        state <= DCB;
                    end
                end
                DCB: begin
                    x_prev <= x;
                    y      <= y_next;
                    if (dcb_clip) O_CLIP <= 1'b1;
`ifdef DK_AUDIO_LPF_EN
                    state  <= LPF;
`else
                    state  <= GAIN;
`endif
                end
`ifdef DK_AUDIO_LPF_EN
                LPF: begin
                    z     <= z_next;
                    if (lpf_clip) O_CLIP <= 1'b1;
                    state <= GAIN;
                end
`endif
                GAIN: begin
                    g     <= gain_sat;
                    if (gain_clip) O_CLIP <= 1'b1;
                    state <= OUT;
                end
                OUT: begin
                    O_AUDIO <= I_MUTE ? 16'h0000 : vol_out;
                    O_VALID <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A strobe the FSM cannot accept is dropped but remembered
            if (I_SAMPLE_VALID && (state != IDLE)) O_OVERRUN <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dk_audio_post.sv
// tb_dk_audio_post: directed checks of dk_audio_post for reset, step, volume, mute, clipping, overrun and mid-run reset.
// Expected values follow DK_AUDIO_LPF_EN the same way the design does.
`timescale 1ns/1ps
module tb_dk_audio_post;

    logic        W_CLK_24M = 1'b0;
    logic        W_RESETn  = 1'b0;
    logic [15:0] I_SAMPLE  = 16'd16384;
    logic        I_SAMPLE_VALID = 1'b0;
    logic [3:0]  I_VOL     = 4'd0;
    logic        I_MUTE    = 1'b0;
    logic [15:0] O_AUDIO;
    logic        O_VALID;
    logic        O_CLIP;
    logic        O_OVERRUN;

    int checks = 0;
    int errors = 0;

`ifdef DK_AUDIO_LPF_EN
    localparam int LAT      = 4;
    localparam int STEP1    = 4096;
    localparam int STEP2    = 7152;
    localparam int VOL3     = 512;
    localparam int NEG_STEP = -4096;
    localparam int SAT1     = -8192;
    localparam int SAT2     = 2078;
    localparam int SAT_CLIP = 0;
`else
    localparam int LAT      = 3;
    localparam int STEP1    = 16384;
    localparam int STEP2    = 16320;
    localparam int VOL3     = 2048;
    localparam int NEG_STEP = -16384;
    localparam int SAT1     = -32768;
    localparam int SAT2     = 32767;
    localparam int SAT_CLIP = 1;
`endif

    dk_audio_post dut (
        .W_CLK_24M      (W_CLK_24M),
        .W_RESETn       (W_RESETn),
        .I_SAMPLE       (I_SAMPLE),
        .I_SAMPLE_VALID (I_SAMPLE_VALID),
        .I_VOL          (I_VOL),
        .I_MUTE         (I_MUTE),
        .O_AUDIO        (O_AUDIO),
        .O_VALID        (O_VALID),
        .O_CLIP         (O_CLIP),
        .O_OVERRUN      (O_OVERRUN)
    );

    always #20 W_CLK_24M = ~W_CLK_24M;

    task automatic checkOutput(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        W_RESETn = 1'b0;
        @(negedge W_CLK_24M);
        @(negedge W_CLK_24M);
        W_RESETn = 1'b1;
        @(negedge W_CLK_24M);
    endtask

    task automatic applyStimulus(input logic [15:0] s);
        @(negedge W_CLK_24M);
        I_SAMPLE       = s;
        I_SAMPLE_VALID = 1'b1;
        @(negedge W_CLK_24M);
        I_SAMPLE_VALID = 1'b0;
    endtask

    // Bounded watch window: counts strobes and records the first one's latency and value
    task automatic collect(input int window, output int nvalid, output int lat, output logic [15:0] audio);
        nvalid = 0;
        lat    = -1;
        audio  = 16'hxxxx;
        for (int i = 1; i <= window; i++) begin
            @(negedge W_CLK_24M);
            if (O_VALID === 1'b1) begin
                nvalid++;
                if (lat < 0) begin
                    lat   = i;
                    audio = O_AUDIO;
                end
            end
        end
    endtask

    initial begin
        int          nv;
        int          lat;
        int          total;
        logic [15:0] a;

        // Reset state and midpoint silence
        doReset();
        checkOutput("rst_audio", $signed(O_AUDIO), 0);
        checkOutput("rst_valid", O_VALID, 0);
        checkOutput("rst_clip", O_CLIP, 0);
        checkOutput("rst_overrun", O_OVERRUN, 0);
        total = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(16'd16384);
            collect(8, nv, lat, a);
            total += nv;
            checkOutput("mid_audio", $signed(a), 0);
        end
        checkOutput("mid_count", total, 10);
        checkOutput("mid_clip", O_CLIP, 0);
        checkOutput("mid_overrun", O_OVERRUN, 0);
        applyStimulus(16'hC000);
        collect(8, nv, lat, a);
        checkOutput("bit15_audio", $signed(a), 0);

        // Step response and leak direction
        doReset();
        applyStimulus(16'd24576);
        collect(8, nv, lat, a);
        checkOutput("step_latency", lat, LAT);
        checkOutput("step_count", nv, 1);
        checkOutput("step_audio", $signed(a), STEP1);
        applyStimulus(16'd24576);
        collect(8, nv, lat, a);
        checkOutput("step2_audio", $signed(a), STEP2);

        // Volume, mute, negative values
        doReset();
        I_VOL = 4'd3;
        applyStimulus(16'd24576);
        collect(8, nv, lat, a);
        checkOutput("vol3_audio", $signed(a), VOL3);
        I_VOL = 4'd0;
        doReset();
        I_MUTE = 1'b1;
        applyStimulus(16'd24576);
        collect(8, nv, lat, a);
        checkOutput("mute_count", nv, 1);
        checkOutput("mute_audio", $signed(a), 0);
        I_MUTE = 1'b0;
        doReset();
        applyStimulus(16'd8192);
        collect(8, nv, lat, a);
        checkOutput("neg_step_audio", $signed(a), NEG_STEP);
        doReset();
        I_VOL = 4'd15;
        applyStimulus(16'd16383);
        collect(8, nv, lat, a);
        checkOutput("minus_one_vol15", $signed(a), -1);
        I_VOL = 4'd0;

        // Full-scale swing to drive the gain clamp
        doReset();
        applyStimulus(16'd0);
        collect(8, nv, lat, a);
        checkOutput("sat1_audio", $signed(a), SAT1);
        checkOutput("sat1_clip", O_CLIP, 0);
        applyStimulus(16'd32767);
        collect(8, nv, lat, a);
        checkOutput("sat2_audio", $signed(a), SAT2);
        checkOutput("sat2_clip", O_CLIP, SAT_CLIP);
        applyStimulus(16'd32767);
        collect(8, nv, lat, a);
        checkOutput("sat3_clip_sticky", O_CLIP, SAT_CLIP);

        // Second strobe two clocks into the first sample
        doReset();
        @(negedge W_CLK_24M);
        I_SAMPLE       = 16'd24576;
        I_SAMPLE_VALID = 1'b1;
        @(negedge W_CLK_24M);
        I_SAMPLE_VALID = 1'b0;
        @(negedge W_CLK_24M);
        I_SAMPLE       = 16'd0;
        I_SAMPLE_VALID = 1'b1;
        @(negedge W_CLK_24M);
        I_SAMPLE_VALID = 1'b0;
        collect(8, nv, lat, a);
        checkOutput("ovr_count", nv, 1);
        checkOutput("ovr_audio", $signed(a), STEP1);
        checkOutput("ovr_flag", O_OVERRUN, 1);

        // Reset in the middle of a sample discards it and clears sticky flags
        applyStimulus(16'd24576);
        @(negedge W_CLK_24M);
        W_RESETn = 1'b0;
        collect(6, nv, lat, a);
        checkOutput("midrst_count", nv, 0);
        checkOutput("midrst_audio", $signed(O_AUDIO), 0);
        checkOutput("midrst_valid", O_VALID, 0);
        checkOutput("midrst_clip", O_CLIP, 0);
        checkOutput("midrst_overrun", O_OVERRUN, 0);
        W_RESETn = 1'b1;
        @(negedge W_CLK_24M);
        applyStimulus(16'd16384);
        collect(8, nv, lat, a);
        checkOutput("post_rst_count", nv, 1);
        checkOutput("post_rst_audio", $signed(a), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
